// File: rtl/upe_serial_rx.sv
// Bit-serial operand receiver: start bit, 80 LSB-first payload bits, stop bit.
// Presents five operand words with a one-cycle frame_valid or frame_err strobe.
module upe_serial_rx #(
  parameter int BIT_TICKS = 102,
  parameter int WIDTH     = 16,
  parameter int NWORDS    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  output logic [WIDTH-1:0] var_x,
  output logic [WIDTH-1:0] var_y,
  output logic [WIDTH-1:0] covar_xy,
  output logic [WIDTH-1:0] dfdx,
  output logic [WIDTH-1:0] dfdy,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             busy
);
  localparam int FRAME_BITS = WIDTH * NWORDS;
  localparam int TW         = $clog2(BIT_TICKS);
  localparam int HALF       = BIT_TICKS / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [1:0]            rx_sync;
  logic                  rx_s;
  logic [TW-1:0]         tick_cnt;
  logic [6:0]            bit_cnt;
  logic [FRAME_BITS-1:0] sr;

  assign rx_s = rx_sync[1];
  assign busy = (state != IDLE);

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      var_x       <= '0;
      var_y       <= '0;
      covar_xy    <= '0;
      dfdx        <= '0;
      dfdy        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick_cnt == TW'(HALF)) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == TW'(BIT_TICKS - 1)) begin
            tick_cnt <= '0;
            sr       <= {rx_s, sr[FRAME_BITS-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 7'(FRAME_BITS - 1)) state <= STOP;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == TW'(BIT_TICKS - 1)) begin
            tick_cnt <= '0;
            state    <= IDLE;
            if (rx_s) begin
              var_x       <= sr[0*WIDTH +: WIDTH];
              var_y       <= sr[1*WIDTH +: WIDTH];
              covar_xy    <= sr[2*WIDTH +: WIDTH];
              dfdx        <= sr[3*WIDTH +: WIDTH];
              dfdy        <= sr[4*WIDTH +: WIDTH];
              frame_valid <= 1'b1;
            end else begin
              frame_err   <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_upe_serial_rx.sv
// Directed bench: short-bit-period instance for framing cases, default instance for latency.
module tb_upe_serial_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx4 = 1'b1, rx102 = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_x, a_y, a_c, a_dx, a_dy, b_x, b_y, b_c, b_dx, b_dy;
  logic a_fv, a_fe, a_busy, b_fv, b_fe, b_busy;

  upe_serial_rx #(.BIT_TICKS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rx(rx4),
    .var_x(a_x), .var_y(a_y), .covar_xy(a_c), .dfdx(a_dx), .dfdy(a_dy),
    .frame_valid(a_fv), .frame_err(a_fe), .busy(a_busy));

  upe_serial_rx u_dut102 (
    .clk(clk), .rst_n(rst_n), .rx(rx102),
    .var_x(b_x), .var_y(b_y), .covar_xy(b_c), .dfdx(b_dx), .dfdy(b_dy),
    .frame_valid(b_fv), .frame_err(b_fe), .busy(b_busy));

  wire [79:0] a_ops = {a_dy, a_dx, a_c, a_y, a_x};
  wire [79:0] b_ops = {b_dy, b_dx, b_c, b_y, b_x};

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  int fv4 = 0, fe4 = 0, both4 = 0, fv102 = 0, fe102 = 0, fv102_t = 0;
  logic [79:0] last_cap = '0, prev_cap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_fv) begin fv4++; prev_cap = last_cap; last_cap = a_ops; end
    if (a_fe) fe4++;
    if (a_fv && a_fe) both4++;
    if (b_fv) begin fv102++; fv102_t = cyc; end
    if (b_fe) fe102++;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit big, input logic v);
    if (big) rx102 = v; else rx4 = v;
  endtask

  // abort_at < 80 stops after that many payload bits (line left as-is)
  task automatic send_frame(input bit big, input logic [79:0] pl, input logic stop, input int abort_at);
    int bt;
    bt = big ? 102 : 4;
    drive(big, 1'b0); wait_cyc(bt);
    for (int i = 0; i < 80; i++) begin
      if (i == abort_at) return;
      drive(big, pl[i]); wait_cyc(bt);
    end
    drive(big, stop); wait_cyc(bt);
    drive(big, 1'b1);
  endtask

  localparam logic [79:0] FR_A   = 80'h3281_0529_0143_1E6D_1395;
  localparam logic [79:0] FR_F   = {5{16'hFFFF}};
  localparam logic [79:0] FR_5   = {5{16'hA5A5}};
  localparam logic [79:0] FR_1   = {5{16'h1111}};

  initial begin
    int t0, lat;
    #1;
    chk("rst_ops", a_ops, 80'h0);
    chk("rst_fv", a_fv, 1'b0);
    chk("rst_fe", a_fe, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(5);

    // good frame
    send_frame(1'b0, FR_A, 1'b1, 80);
    wait_cyc(10);
    chk("good_fv_cnt", 80'(fv4), 80'd1);
    chk("good_fe_cnt", 80'(fe4), 80'd0);
    chk("good_ops", a_ops, FR_A);
    chk("good_busy", a_busy, 1'b0);

    // bad stop bit: different payload must not reach the outputs
    send_frame(1'b0, FR_1, 1'b0, 80);
    drive(1'b0, 1'b1);
    wait_cyc(10);
    chk("err_fe_cnt", 80'(fe4), 80'd1);
    chk("err_fv_cnt", 80'(fv4), 80'd1);
    chk("err_ops", a_ops, FR_A);

    // one-clock glitch while idle
    rx4 = 1'b0; wait_cyc(1); rx4 = 1'b1;
    wait_cyc(20);
    chk("glitch_fv_cnt", 80'(fv4), 80'd1);
    chk("glitch_fe_cnt", 80'(fe4), 80'd1);
    chk("glitch_ops", a_ops, FR_A);
    chk("glitch_busy", a_busy, 1'b0);

    // back-to-back frames, no idle gap
    send_frame(1'b0, FR_F, 1'b1, 80);
    send_frame(1'b0, FR_5, 1'b1, 80);
    wait_cyc(10);
    chk("b2b_fv_cnt", 80'(fv4), 80'd3);
    chk("b2b_first", prev_cap, FR_F);
    chk("b2b_second", last_cap, FR_5);
    chk("b2b_ops", a_ops, FR_5);

    // reset at payload bit 40
    send_frame(1'b0, FR_1, 1'b1, 40);
    rst_n = 1'b0; #1;
    chk("midrst_ops", a_ops, 80'h0);
    chk("midrst_busy", a_busy, 1'b0);
    rx4 = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);
    chk("postrst_ops", a_ops, 80'h0);
    send_frame(1'b0, FR_1, 1'b1, 80);
    wait_cyc(10);
    chk("postrst_fv_cnt", 80'(fv4), 80'd4);
    chk("postrst_ops_1111", a_ops, FR_1);

    // default bit period: latency and values
    t0 = cyc;
    send_frame(1'b1, FR_A, 1'b1, 80);
    for (int k = 0; k < 200 && fv102 == 0; k++) wait_cyc(1);
    chk("d102_fv_cnt", 80'(fv102), 80'd1);
    lat = fv102_t - t0;
    if (lat < 8315 || lat > 8318) $display("latency observed %0d cycles", lat);
    chk("d102_latency_win", 80'(lat >= 8315 && lat <= 8318), 80'd1);
    chk("d102_ops", b_ops, FR_A);
    chk("d102_fe_cnt", 80'(fe102), 80'd0);
    chk("fv_fe_exclusive", 80'(both4), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
